instr_fetch_boot: RTL and testbench
===================================

# instr_fetch_boot

Instruction-fetch stage sitting directly downstream of the BIOS ROM and the main instruction memory. Owns the program counter, drives the fetch address to both sources, and registers the selected 32-bit instruction toward decode. A boot state machine fetches from the BIOS until `biosFinalizada` rises, inserts a one-cycle handoff bubble, then fetches the OS from main instruction memory starting at `OS_START`. Handles stall and taken-branch/jump redirection.

## Interface
- `ADDR_W`, 16: fetch address width.
- `INSTR_W`, 32: instruction width.
- `OS_START`, 16'd0: first OS address in main instruction memory after handoff.
- `NOP_INSTR`, 32'd0: bubble instruction (`add r0,r0,r0`).

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `biosFinalizada`  in  1  BIOS-done flag from the BIOS ROM; once high it stays high until reset.
- `instrBios`  in  32  combinational read data from the BIOS ROM.
- `instrMem`  in  32  combinational read data from main instruction memory.
- `stall`  in  1  hold PC, state and output register.
- `desvio`  in  1  taken branch/jump from execute.
- `destinoDesvio`  in  16  redirect target.
- `enderecoBios`  out  16  BIOS address; equals `pc` in BOOT, 0 otherwise.
- `enderecoMem`  out  16  main-memory address; equals `pc` in EXEC, 0 otherwise.
- `instrucao`  out  32  registered instruction to decode.
- `pcInstrucao`  out  16  address that `instrucao` was fetched from.
- `instrValida`  out  1  `instrucao` is a real instruction, not a bubble.
- `modoBios`  out  1  high while in BOOT or HANDOFF.

## Operation
- States: BOOT, HANDOFF, EXEC.
- Reset:
  - State is BOOT and `pc` = 0.
  - `instrucao` = `NOP_INSTR`, `pcInstrucao` = 0, `instrValida` = 0, `modoBios` = 1.
- Priority each edge: reset > `biosFinalizada` (in BOOT only) > `desvio` > `stall` > normal fetch.
- BOOT, normal fetch:
  - `instrucao` <= `instrBios`, `pcInstrucao` <= `pc`, `instrValida` <= 1.
  - `pc` <= `pc`+1.
- BOOT with `biosFinalizada`=1:
  - Next state HANDOFF.
  - `pc` <= `OS_START`.
  - Output register loads the bubble: `NOP_INSTR`, `instrValida` 0.
  - A simultaneous `desvio` or `stall` is ignored.
- HANDOFF:
  - Unconditional one-cycle bubble (`instrValida` 0); `stall` and `desvio` are ignored.
  - Next state EXEC; `modoBios` <= 0.
- EXEC: same as BOOT but sources `instrMem`. `biosFinalizada` is ignored.
- `desvio` (BOOT or EXEC):
  - `pc` <= `destinoDesvio`.
  - Output register loads the bubble; `desvio` overrides `stall`.
- `stall` (without `desvio`): `pc`, state, `instrucao`, `pcInstrucao` and `instrValida` all hold.
- Arithmetic: `pc`+1 is modulo 2^16, so 16'hFFFF wraps to 0 with no flag.
- `reset` asserted mid-fetch in any state: next edge is the reset state; HANDOFF is abandoned.

## Timing
- Fetch latency: 1 cycle. The address presented at edge N appears on `instrucao` after edge N.
- Boot handoff: `biosFinalizada` sampled high at edge N.
  - Edge N: bubble.
  - Edge N+1: HANDOFF bubble.
  - Edge N+2: first OS instruction `instrMem[OS_START]` valid.
  - Exactly 2 bubbles.
- Branch penalty: `desvio` at edge N gives a bubble at N; `instrucao` = target word after N+1.
- Address outputs are combinational from `pc` and state; no registered address path.

## Structure
- Shared package holds:
  - State enum `{BOOT, HANDOFF, EXEC}`.
  - `ADDR_W` and `INSTR_W` constants.
  - Default `NOP_INSTR`.
- The PC/next-PC mux, source select and output register fit comfortably in one module; no sub-module is warranted.

## Test plan
- Reset, then release with `biosFinalizada`=0 and BIOS words i+100 at address i:
  - `instrucao` = 100, 101, 102 on consecutive cycles.
  - `pcInstrucao` = 0, 1, 2; `modoBios`=1.
- Raise `biosFinalizada` at `pc`=53:
  - Exactly 2 cycles with `instrValida`=0.
  - Then `instrucao`=`instrMem[0]`, `pcInstrucao`=0, `modoBios`=0.
- In EXEC at `pc`=10, assert `desvio` with `destinoDesvio`=40:
  - One bubble, then `pcInstrucao`=40 and `instrucao`=`instrMem[40]`.
- Assert `stall` for 3 cycles at `pc`=7:
  - `instrucao` and `pcInstrucao` frozen.
  - After release, the next word fetched is from address 7, with none skipped.
- In EXEC, set `pc`=16'hFFFF:
  - `pcInstrucao`=16'hFFFF, then 0.
- Assert `reset` during HANDOFF:
  - Next cycle state BOOT, `pc`=0, `instrValida`=0, `enderecoBios`=0.
  - `biosFinalizada`=1 during and after reset is handled per priority (BIOS deasserts it under reset).

Source files
------------

// File: rtl/instr_fetch_boot_pkg.sv
// Shared types and defaults for the boot-aware instruction fetch stage.
package instr_fetch_boot_pkg;

  localparam int ADDR_W = 16;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'd0; // add r0,r0,r0

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    HANDOFF = 2'd1,
    EXEC    = 2'd2
  } boot_state_e;

endpackage

// File: rtl/instr_fetch_boot.sv
// Fetch stage: owns the PC, fetches from BIOS ROM until boot completes, then
// from main instruction memory, with stall and branch redirection.
module instr_fetch_boot
  import instr_fetch_boot_pkg::*;
#(
  parameter int                  ADDR_W    = instr_fetch_boot_pkg::ADDR_W,
  parameter int                  INSTR_W   = instr_fetch_boot_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]   OS_START  = '0,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = instr_fetch_boot_pkg::NOP_INSTR_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                biosFinalizada,
  input  logic [INSTR_W-1:0]  instrBios,
  input  logic [INSTR_W-1:0]  instrMem,
  input  logic                stall,
  input  logic                desvio,
  input  logic [ADDR_W-1:0]   destinoDesvio,
  output logic [ADDR_W-1:0]   enderecoBios,
  output logic [ADDR_W-1:0]   enderecoMem,
  output logic [INSTR_W-1:0]  instrucao,
  output logic [ADDR_W-1:0]   pcInstrucao,
  output logic                instrValida,
  output logic                modoBios,
  output boot_state_e         state_dbg
);

  boot_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pci_q, pci_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               modo_q, modo_d;
  logic [INSTR_W-1:0] fetch_word;

  assign fetch_word = (state_q == EXEC) ? instrMem : instrBios;

  // Bubbles record the PC of the slot they replace; decode ignores it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pci_d   = pci_q;
    instr_d = instr_q;
    valid_d = valid_q;
    modo_d  = modo_q;
    unique case (state_q)
      BOOT, EXEC: begin
        if (state_q == BOOT && biosFinalizada) begin
          state_d = HANDOFF;
          pc_d    = OS_START;
          instr_d = NOP_INSTR;
          pci_d   = pc_q;
          valid_d = 1'b0;
        end else if (desvio) begin
          pc_d    = destinoDesvio;
          instr_d = NOP_INSTR;
          pci_d   = pc_q;
          valid_d = 1'b0;
        end else if (!stall) begin
          pc_d    = pc_q + ADDR_W'(1);
          instr_d = fetch_word;
          pci_d   = pc_q;
          valid_d = 1'b1;
        end
      end
      HANDOFF: begin
        state_d = EXEC;
        modo_d  = 1'b0;
        instr_d = NOP_INSTR;
        pci_d   = pc_q;
        valid_d = 1'b0;
      end
      default: begin
        state_d = BOOT;
        pc_d    = '0;
        instr_d = NOP_INSTR;
        pci_d   = '0;
        valid_d = 1'b0;
        modo_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= '0;
      pci_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      modo_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pci_q   <= pci_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      modo_q  <= modo_d;
    end
  end

  assign enderecoBios = (state_q == BOOT) ? pc_q : '0;
  assign enderecoMem  = (state_q == EXEC) ? pc_q : '0;
  assign instrucao    = instr_q;
  assign pcInstrucao  = pci_q;
  assign instrValida  = valid_q;
  assign modoBios     = modo_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_instr_fetch_boot.sv
// Randomized bench for instr_fetch_boot against an abstract fetch model.
module tb_instr_fetch_boot;
  import instr_fetch_boot_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        biosFinalizada = 1'b0;
  logic [31:0] instrBios, instrMem;
  logic        stall = 1'b0;
  logic        desvio = 1'b0;
  logic [15:0] destinoDesvio = '0;
  logic [15:0] enderecoBios, enderecoMem, pcInstrucao;
  logic [31:0] instrucao;
  logic        instrValida, modoBios;
  boot_state_e state_dbg;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model: mode 0 = booting from BIOS, 1 = handoff bubble, 2 = OS running
  int          m_mode, m_pc, m_pci;
  logic [31:0] m_instr;
  logic        m_valid, m_modo, m_known;

  instr_fetch_boot dut (
    .clock(clock), .reset(reset), .biosFinalizada(biosFinalizada),
    .instrBios(instrBios), .instrMem(instrMem), .stall(stall),
    .desvio(desvio), .destinoDesvio(destinoDesvio),
    .enderecoBios(enderecoBios), .enderecoMem(enderecoMem),
    .instrucao(instrucao), .pcInstrucao(pcInstrucao),
    .instrValida(instrValida), .modoBios(modoBios), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] bios_word(input int a);
    return 32'(a) + 32'd100;
  endfunction

  function automatic logic [31:0] mem_word(input int a);
    logic [15:0] x;
    x = 16'(a);
    return {x ^ 16'h5A5A, ~x};
  endfunction

  always_comb begin
    instrBios = bios_word(int'(enderecoBios));
    instrMem  = mem_word(int'(enderecoMem));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic boot_state_e mode_to_state(input int m);
    return (m == 0) ? BOOT : (m == 1) ? HANDOFF : EXEC;
  endfunction

  task automatic bubble();
    m_instr = 32'd0;
    m_valid = 1'b0;
  endtask

  task automatic model_edge(input logic r, bf, st, dv, input logic [15:0] dst);
    if (r) begin
      m_mode = 0; m_pc = 0; m_pci = 0; m_instr = 32'd0; m_valid = 1'b0; m_modo = 1'b1;
      m_known = 1'b1;
    end else if (m_mode == 1) begin
      m_mode = 2; m_modo = 1'b0; bubble();
    end else if (m_mode == 0 && bf) begin
      m_mode = 1; m_pc = 0; bubble();
    end else if (dv) begin
      m_pc = int'(dst); bubble();
    end else if (!st) begin
      m_instr = (m_mode == 0) ? bios_word(m_pc) : mem_word(m_pc);
      m_pci   = m_pc;
      m_valid = 1'b1;
      m_pc    = (m_pc + 1) % 65536;
    end
  endtask

  // Drive one cycle of inputs, advance model and DUT, then compare everything.
  task automatic step(input logic r, bf, st, dv, input logic [15:0] dst);
    reset = r; biosFinalizada = bf; stall = st; desvio = dv; destinoDesvio = dst;
    if (m_known) begin
      check_eq("enderecoBios", 32'(enderecoBios), (m_mode == 0) ? 32'(m_pc) : 32'd0);
      check_eq("enderecoMem", 32'(enderecoMem), (m_mode == 2) ? 32'(m_pc) : 32'd0);
    end
    @(posedge clock);
    model_edge(r, bf, st, dv, dst);
    #1;
    check_eq("state", 32'(state_dbg), 32'(mode_to_state(m_mode)));
    check_eq("instrucao", instrucao, m_instr);
    check_eq("instrValida", 32'(instrValida), 32'(m_valid));
    check_eq("modoBios", 32'(modoBios), 32'(m_modo));
    if (m_valid || r) check_eq("pcInstrucao", 32'(pcInstrucao), 32'(m_pci));
  endtask

  task automatic fetch(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'd0);
  endtask

  initial begin
    int guard;
    m_known = 1'b0;
    m_mode = 0; m_pc = 0; m_pci = 0; m_instr = '0; m_valid = 0; m_modo = 1;

    // Reset state, then first BIOS words
    step(1, 0, 0, 0, 16'd0);
    step(1, 0, 0, 0, 16'd0);
    check_eq("rst_state", 32'(state_dbg), 32'(BOOT));
    check_eq("rst_instr", instrucao, 32'd0);
    check_eq("rst_valid", 32'(instrValida), 32'd0);
    check_eq("rst_modo", 32'(modoBios), 32'd1);
    step(0, 0, 0, 0, 16'd0);
    check_eq("boot_w0", instrucao, 32'd100);
    check_eq("boot_pc0", 32'(pcInstrucao), 32'd0);
    step(0, 0, 0, 0, 16'd0);
    check_eq("boot_w1", instrucao, 32'd101);
    step(0, 0, 0, 0, 16'd0);
    check_eq("boot_w2", instrucao, 32'd102);
    check_eq("boot_pc2", 32'(pcInstrucao), 32'd2);

    // Random BIOS traffic with redirects and stalls
    for (int i = 0; i < 60; i++)
      step(0, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           16'($urandom_range(0, 40)));
    step(0, 0, 0, 1, 16'd50);
    guard = 0;
    while (m_pc != 53 && guard < 100) begin
      step(0, 0, $urandom_range(0, 2) == 0, 0, 16'd0);
      guard++;
    end
    check_eq("reach_pc53", 32'(m_pc), 32'd53);

    // Handoff: exactly two bubbles, a concurrent desvio/stall is ignored
    step(0, 1, 1, 1, 16'h1234);
    check_eq("ho_bubble1", 32'(instrValida), 32'd0);
    step(0, 1, 1, 1, 16'h4321);
    check_eq("ho_bubble2", 32'(instrValida), 32'd0);
    step(0, 1, 0, 0, 16'd0);
    check_eq("os_first_valid", 32'(instrValida), 32'd1);
    check_eq("os_first_word", instrucao, mem_word(0));
    check_eq("os_first_pc", 32'(pcInstrucao), 32'd0);
    check_eq("os_modo", 32'(modoBios), 32'd0);

    // Branch at pc=10 to 40
    step(0, 1, 0, 1, 16'd10);
    check_eq("pc_at_10", 32'(m_pc), 32'd10);
    step(0, 1, 0, 1, 16'd40);
    check_eq("br_bubble", 32'(instrValida), 32'd0);
    step(0, 1, 0, 0, 16'd0);
    check_eq("br_target_pc", 32'(pcInstrucao), 32'd40);
    check_eq("br_target_word", instrucao, mem_word(40));

    // Stall three cycles at pc=7, then resume without skipping
    step(0, 1, 0, 1, 16'd7);
    fetch(1);
    step(0, 1, 0, 1, 16'd7);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 16'd0);
    step(0, 1, 0, 0, 16'd0);
    check_eq("stall_resume_pc", 32'(pcInstrucao), 32'd7);
    check_eq("stall_resume_word", instrucao, mem_word(7));

    // PC wrap
    step(0, 1, 0, 1, 16'hFFFF);
    step(0, 1, 0, 0, 16'd0);
    check_eq("wrap_ffff", 32'(pcInstrucao), 32'h0000FFFF);
    step(0, 1, 0, 0, 16'd0);
    check_eq("wrap_zero", 32'(pcInstrucao), 32'd0);

    // Random OS traffic; biosFinalizada stays high
    for (int i = 0; i < 400; i++)
      step(0, 1, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           16'($urandom()));

    // Reset during HANDOFF
    step(1, 1, 0, 0, 16'd0);
    fetch(3);
    step(0, 1, 0, 0, 16'd0);
    check_eq("in_handoff", 32'(state_dbg), 32'(HANDOFF));
    step(1, 1, 1, 1, 16'd9);
    check_eq("ho_rst_state", 32'(state_dbg), 32'(BOOT));
    check_eq("ho_rst_valid", 32'(instrValida), 32'd0);
    check_eq("ho_rst_addr", 32'(enderecoBios), 32'd0);
    check_eq("ho_rst_modo", 32'(modoBios), 32'd1);
    fetch(4);
    check_eq("reboot_w3", instrucao, 32'd103);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
